mult_io_sequencer: RTL and testbench

Nibble-serial operand loader and result unloader for the pad-limited 8-bit Wallace tree multiplier prototype. Assembles two 8-bit operands from a 4-bit input pad bus and holds them stable on the multiplier inputs. Waits a programmable settle time, captures the multiplier's combinational product, and shifts it out over a 4-bit output pad bus. Sits directly around the multiplier: upstream of its `A`/`B` inputs, downstream of its `Out`.

---
 rtl/mult_io_sequencer_if.sv | 31 +++
 rtl/mult_io_sequencer.sv | 110 +++++++++++
 tb/tb_mult_io_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_io_sequencer_if.sv
// Nibble pad handshake bundle for mult_io_sequencer.
// MULT_IO_PARITY_EN adds the out_par parity line.
interface mult_io_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_nib;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_nib;
`ifdef MULT_IO_PARITY_EN
   logic       out_par;

   modport master (
      output in_valid, in_nib, out_ready,
      input  in_ready, out_valid, out_nib, out_par
   );
   modport slave (
      input  in_valid, in_nib, out_ready,
      output in_ready, out_valid, out_nib, out_par
   );
`else
   modport master (
      output in_valid, in_nib, out_ready,
      input  in_ready, out_valid, out_nib
   );
   modport slave (
      input  in_valid, in_nib, out_ready,
      output in_ready, out_valid, out_nib
   );
`endif
endinterface

// File: rtl/mult_io_sequencer.sv
// Nibble-serial operand loader / product unloader around the multiplier.
// MULT_IO_PARITY_EN adds out_par, even parity over out_nib.
module mult_io_sequencer #(
   parameter int PW         = 8,
   parameter int SETTLE_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_io_sequencer_if.slave   io,
   output logic [7:0]           mult_a,
   output logic [7:0]           mult_b,
   input  logic [PW-1:0]        mult_p
);
   typedef enum logic [1:0] {LOAD, SETTLE, CAPTURE, UNLOAD} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [3:0] NIB_LAST    = 4'(PW / 4 - 1);

   state_t        state, state_nx;
   logic [1:0]    idx;
   logic [7:0]    shadow_a;
   logic [3:0]    shadow_b;
   logic [3:0]    cnt;
   logic [PW-1:0] shift;
   logic          in_acc;
   logic          out_acc;
`ifdef MULT_IO_PARITY_EN
   logic          par;

   assign io.out_par = par;
`endif

   assign in_acc     = (state == LOAD) && io.in_valid;
   assign out_acc    = (state == UNLOAD) && io.out_ready;
   assign io.out_nib = shift[3:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nx;
   end

   // Handshake outputs decode the state register only.
   always_comb begin
      state_nx     = state;
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      unique case (state)
         LOAD: begin
            io.in_ready = 1'b1;
            if (io.in_valid && idx == 2'd3) state_nx = SETTLE;
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) state_nx = CAPTURE;
         end
         CAPTURE: state_nx = UNLOAD;
         UNLOAD: begin
            io.out_valid = 1'b1;
            if (io.out_ready && cnt == NIB_LAST) state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         shadow_a <= '0;
         shadow_b <= '0;
         cnt      <= '0;
         shift    <= '0;
         mult_a   <= '0;
         mult_b   <= '0;
`ifdef MULT_IO_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         unique case (1'b1)
            in_acc: begin
               idx <= idx + 2'd1;
               unique case (idx)
                  2'd0: shadow_a[3:0] <= io.in_nib;
                  2'd1: shadow_a[7:4] <= io.in_nib;
                  2'd2: shadow_b      <= io.in_nib;
                  2'd3: begin
                     mult_a <= shadow_a;
                     mult_b <= {io.in_nib, shadow_b};
                     cnt    <= '0;
                  end
               endcase
            end
            (state == SETTLE): cnt <= cnt + 4'd1;
            (state == CAPTURE): begin
               shift <= mult_p;
               cnt   <= '0;
`ifdef MULT_IO_PARITY_EN
               par   <= ^mult_p[3:0];
`endif
            end
            out_acc: begin
               shift <= shift >> 4;
               cnt   <= cnt + 4'd1;
`ifdef MULT_IO_PARITY_EN
               par   <= (cnt == NIB_LAST) ? 1'b0 : ^shift[7:4];
`endif
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_io_sequencer.sv
// Directed bench for mult_io_sequencer: PW=8/SETTLE=2 and PW=16/SETTLE=1.
// Define MULT_IO_PARITY_EN to also check out_par.
module tb_mult_io_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mult_io_sequencer_if io8 ();
   mult_io_sequencer_if io16 ();

   logic [7:0]  a8, b8, a16, b16;
   logic [7:0]  p8;
   logic [15:0] p16;

   // Behavioural multiplier standing in for the Wallace tree.
   assign p8  = a8 * b8;
   assign p16 = 16'(a16) * 16'(b16);

   mult_io_sequencer dut8 (
      .clk(clk), .rst(rst), .io(io8),
      .mult_a(a8), .mult_b(b8), .mult_p(p8)
   );

   mult_io_sequencer #(.PW(16), .SETTLE_CYC(1)) dut16 (
      .clk(clk), .rst(rst), .io(io16),
      .mult_a(a16), .mult_b(b16), .mult_p(p16)
   );

   int checks = 0;
   int fails  = 0;

   // Presents nibbles first..last of w on io8, gap idle cycles between.
   task automatic load_nibs(input logic [15:0] w, input int first,
                            input int last, input int gap);
      int n;
      for (int i = first; i <= last; i++) begin
         if (i > first) begin
            io8.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         io8.in_valid = 1'b1;
         io8.in_nib   = w[i*4 +: 4];
         n = 0;
         while (!io8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) begin
            checks++; fails++;
            $display("FAIL load_timeout nib %0d: in_ready never rose", i);
         end
         @(negedge clk);
      end
      io8.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      io8.in_valid = 1'b0; io8.in_nib = '0; io8.out_ready = 1'b0;
      io16.in_valid = 1'b0; io16.in_nib = '0; io16.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (io8.in_ready !== 1'b1) begin fails++;
         $display("FAIL rst_in_ready got %b want 1", io8.in_ready); end
      checks++;
      if (io8.out_valid !== 1'b0) begin fails++;
         $display("FAIL rst_out_valid got %b want 0", io8.out_valid); end
      checks++;
      if (io8.out_nib !== 4'h0) begin fails++;
         $display("FAIL rst_out_nib got %h want 0", io8.out_nib); end
      checks++;
      if (a8 !== 8'h00 || b8 !== 8'h00) begin fails++;
         $display("FAIL rst_ab got %h/%h want 00/00", a8, b8); end
      checks++;
      if (io16.in_ready !== 1'b1 || io16.out_valid !== 1'b0) begin fails++;
         $display("FAIL rst16 got rdy %b vld %b want 1/0",
                  io16.in_ready, io16.out_valid); end
`ifdef MULT_IO_PARITY_EN
      checks++;
      if (io8.out_par !== 1'b0) begin fails++;
         $display("FAIL rst_par got %b want 0", io8.out_par); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [3:0] exp_nib [2];
      logic       exp_par [2];
      int k;
      exp_nib = '{4'hF, 4'h8};
      exp_par = '{1'b0, 1'b1};
      io8.out_ready = 1'b1;
      load_nibs(16'h0B0D, 0, 3, 0);
      checks++;
      if (a8 !== 8'h0D || b8 !== 8'h0B) begin fails++;
         $display("FAIL basic_ab got %h/%h want 0d/0b", a8, b8); end
      checks++;
      if (io8.in_ready !== 1'b0) begin fails++;
         $display("FAIL basic_busy got %b want 0", io8.in_ready); end
      k = 0;
      while (!io8.out_valid && k < 20) begin @(negedge clk); k++; end
      checks++;
      if (k != 3) begin fails++;
         $display("FAIL basic_latency got %0d want 3", k); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (io8.out_nib !== exp_nib[i]) begin fails++;
            $display("FAIL basic_nib%0d got %h want %h",
                     i, io8.out_nib, exp_nib[i]); end
`ifdef MULT_IO_PARITY_EN
         checks++;
         if (io8.out_par !== exp_par[i]) begin fails++;
            $display("FAIL basic_par%0d got %b want %b",
                     i, io8.out_par, exp_par[i]); end
`endif
         @(negedge clk);
      end
      checks++;
      if (io8.out_valid !== 1'b0 || io8.in_ready !== 1'b1) begin fails++;
         $display("FAIL basic_done got vld %b rdy %b want 0/1",
                  io8.out_valid, io8.in_ready); end
   endtask

   task automatic test_backpressure();
      logic [3:0] exp_nib [2];
      int k;
      exp_nib = '{4'hF, 4'h8};
      io8.out_ready = 1'b0;
      load_nibs(16'h0B0D, 0, 3, 0);
      k = 0;
      while (!io8.out_valid && k < 20) begin @(negedge clk); k++; end
      checks++;
      if (k >= 20) begin fails++;
         $display("FAIL bp_timeout out_valid got 0 want 1"); end
      // Stray input nibbles during the stall must not be consumed.
      io8.in_valid = 1'b1;
      io8.in_nib   = 4'h7;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (io8.out_valid !== 1'b1 || io8.out_nib !== 4'hF
             || io8.in_ready !== 1'b0) begin fails++;
            $display("FAIL bp_hold%0d got vld %b nib %h rdy %b want 1/f/0",
                     i, io8.out_valid, io8.out_nib, io8.in_ready); end
         @(negedge clk);
      end
      io8.in_valid  = 1'b0;
      io8.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (io8.out_nib !== exp_nib[i] || io8.in_ready !== 1'b0)
         begin fails++;
            $display("FAIL bp_nib%0d got %h rdy %b want %h/0",
                     i, io8.out_nib, io8.in_ready, exp_nib[i]); end
         @(negedge clk);
      end
      checks++;
      if (io8.out_valid !== 1'b0 || io8.in_ready !== 1'b1) begin fails++;
         $display("FAIL bp_done got vld %b rdy %b want 0/1",
                  io8.out_valid, io8.in_ready); end
   endtask

   task automatic test_input_gaps();
      logic [3:0] exp_nib [2];
      logic       exp_par [2];
      int k;
      exp_nib = '{4'h1, 4'h0};
      exp_par = '{1'b1, 1'b0};
      io8.out_ready = 1'b1;
      load_nibs(16'hFFFF, 0, 2, 2);
      repeat (2) @(negedge clk);
      checks++;
      if (a8 !== 8'h0D || b8 !== 8'h0B) begin fails++;
         $display("FAIL gap_hold got %h/%h want 0d/0b", a8, b8); end
      load_nibs(16'hFFFF, 3, 3, 0);
      checks++;
      if (a8 !== 8'hFF || b8 !== 8'hFF) begin fails++;
         $display("FAIL gap_ab got %h/%h want ff/ff", a8, b8); end
      k = 0;
      while (!io8.out_valid && k < 20) begin @(negedge clk); k++; end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (io8.out_valid !== 1'b1 || io8.out_nib !== exp_nib[i])
         begin fails++;
            $display("FAIL gap_nib%0d got vld %b nib %h want 1/%h",
                     i, io8.out_valid, io8.out_nib, exp_nib[i]); end
`ifdef MULT_IO_PARITY_EN
         checks++;
         if (io8.out_par !== exp_par[i]) begin fails++;
            $display("FAIL gap_par%0d got %b want %b",
                     i, io8.out_par, exp_par[i]); end
`endif
         @(negedge clk);
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] exp_nib [2];
      int k;
      exp_nib = '{4'hF, 4'h0};
      io8.out_ready = 1'b1;
      load_nibs(16'h0077, 0, 1, 0);
      rst = 1'b1;
      #1;
      checks++;
      if (a8 !== 8'h00 || b8 !== 8'h00 || io8.in_ready !== 1'b1
          || io8.out_valid !== 1'b0 || io8.out_nib !== 4'h0) begin fails++;
         $display("FAIL mrst_load got %h/%h rdy %b vld %b nib %h",
                  a8, b8, io8.in_ready, io8.out_valid, io8.out_nib); end
      @(negedge clk);
      rst = 1'b0;
      load_nibs(16'h0909, 0, 3, 0);
      checks++;
      if (a8 !== 8'h09 || io8.in_ready !== 1'b0) begin fails++;
         $display("FAIL mrst_pre got %h rdy %b want 09/0",
                  a8, io8.in_ready); end
      rst = 1'b1;
      #1;
      checks++;
      if (a8 !== 8'h00 || b8 !== 8'h00 || io8.in_ready !== 1'b1
          || io8.out_valid !== 1'b0) begin fails++;
         $display("FAIL mrst_settle got %h/%h rdy %b vld %b",
                  a8, b8, io8.in_ready, io8.out_valid); end
`ifdef MULT_IO_PARITY_EN
      checks++;
      if (io8.out_par !== 1'b0) begin fails++;
         $display("FAIL mrst_par got %b want 0", io8.out_par); end
`endif
      @(negedge clk);
      rst = 1'b0;
      load_nibs(16'h0503, 0, 3, 0);
      k = 0;
      while (!io8.out_valid && k < 20) begin @(negedge clk); k++; end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (io8.out_valid !== 1'b1 || io8.out_nib !== exp_nib[i])
         begin fails++;
            $display("FAIL mrst_nib%0d got vld %b nib %h want 1/%h",
                     i, io8.out_valid, io8.out_nib, exp_nib[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_pw16();
      logic [3:0] exp_nib [4];
      logic       exp_par [4];
      int k;
      exp_nib = '{4'h1, 4'h0, 4'hE, 4'hF};
      exp_par = '{1'b1, 1'b0, 1'b1, 1'b0};
      io16.out_ready = 1'b1;
      io16.in_nib    = 4'hF;
      io16.in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (io16.in_ready !== 1'b1) begin fails++;
            $display("FAIL pw16_rdy%0d got %b want 1", i, io16.in_ready); end
         @(negedge clk);
      end
      io16.in_valid = 1'b0;
      checks++;
      if (a16 !== 8'hFF || b16 !== 8'hFF) begin fails++;
         $display("FAIL pw16_ab got %h/%h want ff/ff", a16, b16); end
      k = 0;
      while (!io16.out_valid && k < 20) begin @(negedge clk); k++; end
      checks++;
      if (k != 2) begin fails++;
         $display("FAIL pw16_latency got %0d want 2", k); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (io16.out_valid !== 1'b1 || io16.out_nib !== exp_nib[i])
         begin fails++;
            $display("FAIL pw16_nib%0d got vld %b nib %h want 1/%h",
                     i, io16.out_valid, io16.out_nib, exp_nib[i]); end
`ifdef MULT_IO_PARITY_EN
         checks++;
         if (io16.out_par !== exp_par[i]) begin fails++;
            $display("FAIL pw16_par%0d got %b want %b",
                     i, io16.out_par, exp_par[i]); end
`endif
         @(negedge clk);
      end
      checks++;
      if (io16.out_valid !== 1'b0 || io16.in_ready !== 1'b1) begin fails++;
         $display("FAIL pw16_done got vld %b rdy %b want 0/1",
                  io16.out_valid, io16.in_ready); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_input_gaps();
      test_mid_reset();
      test_pw16();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end
endmodule
